// File: rtl/knn_dist_pkg.sv
`default_nettype none
// ============================================================================
// Module  : knn_dist_pkg
// Purpose : Shared definitions for the k-NN distance stage: FSM state
//           encoding, pipeline depth and point field extraction helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package knn_dist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles from an accepted training point to its dist_valid strobe.
  localparam int KNN_DIST_LAT = 3;

  // Widest coordinate the field helpers support.
  localparam int MAX_COORD_W = 32;

  // A point packs x in the upper half and y in the lower half; w is the
  // coordinate width actually in use.
  function automatic logic [MAX_COORD_W-1:0] point_x(
    input logic [2*MAX_COORD_W-1:0] p,
    input int unsigned              w
  );
    return MAX_COORD_W'((p >> w) & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic logic [MAX_COORD_W-1:0] point_y(
    input logic [2*MAX_COORD_W-1:0] p,
    input int unsigned              w
  );
    return MAX_COORD_W'(p & ((64'd1 << w) - 64'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_dist_pipe.sv
`default_nettype none
// ============================================================================
// Module  : knn_dist_pipe
// Purpose : 3-stage squared Euclidean distance pipeline with valid and index
//           sideband. S1 differences, S2 squares, S3 sum + saturation.
// Ports   : clk, rst (async, active-low)
//           in_valid/in_idx  - new point enters S1
//           xt,yt / xd,yd    - test and training coordinates
//           in_flight        - S1 or S2 holds a valid point
//           out_valid/out_dist/out_idx - result strobe; data holds when idle
// Revision: 1.0 - initial release
// ============================================================================
module knn_dist_pipe #(
  parameter int COORD_W = 16,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [COORD_W-1:0] xt,
  input  logic [COORD_W-1:0] yt,
  input  logic [COORD_W-1:0] xd,
  input  logic [COORD_W-1:0] yd,
  output logic               in_flight,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_dist,
  output logic [IDX_W-1:0]   out_idx
);

  localparam int SUM_W = 2*COORD_W + 1;

  logic                      v1, v2;
  logic [IDX_W-1:0]          idx1, idx2;
  logic signed [COORD_W:0]   dx, dy;
  logic [2*COORD_W-1:0]      sx, sy;

  // |d| <= 2^COORD_W - 1 so the magnitude fits COORD_W bits; squaring the
  // magnitude keeps the multiply unsigned and exactly 2*COORD_W wide.
  logic [COORD_W-1:0]        adx, ady;
  logic [2*COORD_W-1:0]      adx_ext, ady_ext;
  logic [SUM_W-1:0]          sum;
  logic [DATA_W-1:0]         sat;

  assign adx     = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
  assign ady     = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
  assign adx_ext = {{COORD_W{1'b0}}, adx};
  assign ady_ext = {{COORD_W{1'b0}}, ady};
  assign sum     = {1'b0, sx} + {1'b0, sy};

  generate
    if (SUM_W > DATA_W) begin : g_sat
      assign sat = (|sum[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    end else begin : g_nosat
      assign sat = DATA_W'(sum);
    end
  endgenerate

  // The output register is not counted: the last strobe may overlap the
  // cycle in which the FSM decides to finish.
  assign in_flight = v1 | v2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      idx1      <= '0;
      idx2      <= '0;
      out_idx   <= '0;
      dx        <= '0;
      dy        <= '0;
      sx        <= '0;
      sy        <= '0;
      out_dist  <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        idx1 <= in_idx;
        dx   <= $signed({1'b0, xt}) - $signed({1'b0, xd});
        dy   <= $signed({1'b0, yt}) - $signed({1'b0, yd});
      end
      if (v1) begin
        idx2 <= idx1;
        sx   <= adx_ext * adx_ext;
        sy   <= ady_ext * ady_ext;
      end
      if (v2) begin
        out_idx  <= idx2;
        out_dist <= sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/knn_dist.sv
`default_nettype none
// ============================================================================
// Module  : knn_dist
// Purpose : Distance stage feeding the k-NN list. Latches a test point,
//           accepts nbr_points training points and strobes one squared
//           distance per point, bracketed by a start/busy/done FSM.
// Ports   : clk, rst (async, active-low)
//           start, test_point, nbr_points - run control (sampled in IDLE)
//           data_valid, data_point, data_ready - training point handshake
//           dist_valid, dist_out, dist_idx - result strobe to the list
//           busy, done                    - run status
// Revision: 1.0 - initial release
// ============================================================================
module knn_dist
  import knn_dist_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*COORD_W-1:0] test_point,
  input  logic [IDX_W-1:0]     nbr_points,
  input  logic                 data_valid,
  input  logic [2*COORD_W-1:0] data_point,
  output logic                 data_ready,
  output logic                 dist_valid,
  output logic [DATA_W-1:0]    dist_out,
  output logic [IDX_W-1:0]     dist_idx,
  output logic                 busy,
  output logic                 done
);

  state_t               state, next;
  logic [IDX_W-1:0]     count, nbr_lat;
  logic [2*COORD_W-1:0] tp;
  logic                 transfer, last, in_flight, accept;
  logic [COORD_W-1:0]   xt, yt, xd, yd;

  assign xt = COORD_W'(point_x(64'(tp), COORD_W));
  assign yt = COORD_W'(point_y(64'(tp), COORD_W));
  assign xd = COORD_W'(point_x(64'(data_point), COORD_W));
  assign yd = COORD_W'(point_y(64'(data_point), COORD_W));

  assign accept   = (state == IDLE) && start && (nbr_points != '0);
  assign transfer = (state == LOAD) && data_valid;
  // A run holds at most 2^IDX_W - 1 points, so count + 1 never wraps.
  assign last     = transfer && ((count + IDX_W'(1)) == nbr_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      nbr_lat <= '0;
      tp      <= '0;
    end else begin
      state <= next;
      if (accept) begin
        tp      <= test_point;
        nbr_lat <= nbr_points;
        count   <= '0;
      end else if (transfer) begin
        count <= count + IDX_W'(1);
      end
    end
  end

  always_comb begin
    next       = state;
    data_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next = (nbr_points != '0) ? LOAD : DONE;
      end
      LOAD: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (last) next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!in_flight) next = DONE;
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  knn_dist_pipe #(
    .COORD_W(COORD_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (transfer),
    .in_idx   (count),
    .xt       (xt),
    .yt       (yt),
    .xd       (xd),
    .yd       (yd),
    .in_flight(in_flight),
    .out_valid(dist_valid),
    .out_dist (dist_out),
    .out_idx  (dist_idx)
  );

endmodule
`default_nettype wire

// File: doc/knn_dist.md
Name: knn_dist

Overview:
- Distance-computation stage directly upstream of the k-nearest-neighbour list.
- Holds one test point and accepts a stream of training points on a valid/ready handshake.
- Computes the squared Euclidean distance to each training point in a 3-stage pipeline.
- Drives each result, with its point index, as a one-cycle valid strobe into the list's enable and distance inputs; a start/busy/done FSM brackets each run.

Parameters:
- COORD_W, 16, width of one unsigned coordinate; a point is 2*COORD_W bits wide, x in the upper half, y in the lower half.
- DATA_W, 32, width of the distance output; results wider than this saturate.
- IDX_W, 16, width of the point counter and point index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- start  input  1  begin a run; sampled only in IDLE.
- test_point  input  2*COORD_W  test point; latched on accepted start.
- nbr_points  input  IDX_W  number of training points in the run; latched on accepted start.
- data_valid  input  1  training point present on data_point.
- data_point  input  2*COORD_W  training point.
- data_ready  output  1  block accepts data_point this cycle.
- dist_valid  output  1  one-cycle strobe: dist_out and dist_idx are valid.
- dist_out  output  DATA_W  squared distance, saturated.
- dist_idx  output  IDX_W  index of the point, 0-based, in acceptance order.
- busy  output  1  high from the cycle after start through the cycle before done.
- done  output  1  one-cycle pulse after the last result.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0: data_ready, dist_valid, dist_out, dist_idx, busy, done.
  - Pipeline valid bits, point counter and latched registers are cleared.
  - A reset mid-run discards all in-flight results; no dist_valid is produced for them.
- FSM states are IDLE, LOAD, DRAIN, DONE. Transitions:
  - IDLE, start=1, nbr_points!=0: latch test_point and nbr_points, clear the counter, go to LOAD.
  - IDLE, start=1, nbr_points=0: go to DONE directly; no dist_valid is emitted.
  - LOAD: data_ready=1. A transfer occurs when data_valid & data_ready. On each transfer the counter increments. On the transfer that brings the count to nbr_points, go to DRAIN.
  - DRAIN: data_ready=0. Go to DONE when all pipeline valid bits are 0.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored; test_point and nbr_points are not re-latched.
- busy = 1 in LOAD and DRAIN, 0 otherwise.
- Pipeline stages; each stage carries its own valid bit and the point index:
  - S1: dx = x_t - x_d and dy = y_t - y_d, signed, COORD_W+1 bits.
  - S2: sx = dx*dx and sy = dy*dy, unsigned, 2*COORD_W bits; cannot overflow because |d| <= 2^COORD_W - 1.
  - S3: sum = sx + sy, 2*COORD_W+1 bits. If sum > 2^DATA_W - 1, dist_out = all ones; else dist_out = sum[DATA_W-1:0].
- Latency: a point transferred in cycle N gives dist_valid=1 in cycle N+3.
- Throughput: one point per cycle. There is no downstream back-pressure; dist_valid is a pure strobe.
- dist_out and dist_idx hold their last values when dist_valid=0.
- Gaps in data_valid propagate as bubbles; results keep acceptance order.
- Last result: the final dist_valid occurs no later than the cycle before done. done never coincides with dist_valid.
- Counter width: a run covers at most 2^IDX_W - 1 points; the counter does not wrap within a run.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, LOAD=1, DRAIN=2, DONE=3);
  - the pipeline depth constant KNN_DIST_LAT=3;
  - the point field extraction (x = upper COORD_W, y = lower COORD_W), shared with the list/top level.
- One sub-module is natural: knn_dist_pipe, the 3-stage arithmetic pipeline with valid/index sideband. The FSM, counter and handshake stay in knn_dist.

Test Plan:
1. test=(3,4), nbr_points=2, points (0,0) then (6,8) on consecutive cycles -> dist_valid in cycles N+3 and N+4 with dist_out=25/idx 0, then dist_out=25/idx 1; done one cycle after the last result.
2. test=(0,0), points (65535,0) and (65535,65535) -> dist_out=0xFFFE0001, then 0xFFFFFFFF (saturated).
3. start with nbr_points=0 -> done pulses with busy never asserted, no dist_valid, data_ready stays 0.
4. nbr_points=4 with data_valid toggling 1,0,0,1,1,0,1 -> exactly 4 strobes, idx 0..3 in order, each 3 cycles after its transfer; data_ready drops after the 4th transfer.
5. Assert start with a new test_point while in LOAD -> ignored; results still use the original test point, and the point count is unchanged.
6. rst low for 1 cycle while 2 results are in flight -> all outputs 0 immediately, no further dist_valid, FSM in IDLE; a new run afterwards starts at idx 0.
